// File: rtl/wishbone_pkg.sv
// wishbone_pkg: shared Wishbone B4 burst tags and arbiter state encoding
package wishbone_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;
    typedef enum logic {ST_ARB, ST_OWN} arb_state_e;
endpackage

// File: rtl/wb_rr_picker.sv
// wb_rr_picker: first requester at or after ptr, searching upward with wrap
module wb_rr_picker #(
    parameter int NUM_M = 4,
    parameter int IW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [NUM_M-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);
    logic          found;
    logic [IW-1:0] j;
    // scan from ptr upward; the first hit wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < NUM_M; k++) begin
            j = IW'((int'(ptr_i) + k) % NUM_M);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end
endmodule

// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter: round-robin sharing of one Wishbone slave with a per-access watchdog
module wishbone_arbiter
    import wishbone_pkg::*;
#(
    parameter int NUM_M     = 4,
    parameter int WB_ADDR_W = 32,
    parameter int WB_DATA_W = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                           CLK_I,
    input  logic                           RST_I,
    input  logic [NUM_M-1:0]               m_cyc_i,
    input  logic [NUM_M-1:0]               m_stb_i,
    input  logic [NUM_M-1:0]               m_we_i,
    input  logic [NUM_M-1:0]               m_lock_i,
    input  logic [NUM_M*WB_ADDR_W-1:0]     m_adr_i,
    input  logic [NUM_M*WB_DATA_W-1:0]     m_dat_i,
    input  logic [NUM_M*WB_DATA_W/8-1:0]   m_sel_i,
    input  logic [NUM_M*3-1:0]             m_cti_i,
    input  logic [NUM_M*2-1:0]             m_bte_i,
    output logic [NUM_M-1:0]               m_ack_o,
    output logic [NUM_M-1:0]               m_err_o,
    output logic [NUM_M-1:0]               m_rty_o,
    output logic [WB_DATA_W-1:0]           m_dat_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    output logic                           s_we_o,
    output logic                           s_lock_o,
    output logic [WB_ADDR_W-1:0]           s_adr_o,
    output logic [WB_DATA_W-1:0]           s_dat_o,
    output logic [WB_DATA_W/8-1:0]         s_sel_o,
    output logic [2:0]                     s_cti_o,
    output logic [1:0]                     s_bte_o,
    input  logic [WB_DATA_W-1:0]           s_dat_i,
    input  logic                           s_ack_i,
    input  logic                           s_err_i,
    input  logic                           s_rty_i,
    output logic [NUM_M-1:0]               gnt_o,
    output logic                           timeout_o
);
    localparam int          IW      = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int          SW      = WB_DATA_W / 8;
    localparam logic [9:0]  WD_TERM = 10'(TIMEOUT);

    arb_state_e        state_q;
    logic [NUM_M-1:0]  gnt_q, pick_gnt;
    logic [IW-1:0]     owner_q, rr_ptr_q, pick_idx;
    logic [9:0]        wd_q, wd_d;
    logic              own, o_cyc, o_stb, o_lock, term, fire, rel;

    wb_rr_picker #(.NUM_M(NUM_M), .IW(IW)) u_pick (
        .req_i (m_cyc_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign own    = state_q == ST_OWN;
    assign o_cyc  = own & m_cyc_i[owner_q];
    assign o_stb  = o_cyc & m_stb_i[owner_q];
    assign o_lock = own & m_lock_i[owner_q];
    // a slave termination beats a watchdog expiring in the same cycle
    assign term   = o_cyc & (s_ack_i | s_err_i | s_rty_i);
    assign fire   = o_stb & ~term & (wd_q == WD_TERM);
    assign rel    = own & (fire | (~o_cyc & ~o_lock));

    assign s_cyc_o  = o_cyc & ~fire;
    assign s_stb_o  = o_stb & ~fire;
    assign s_we_o   = own & m_we_i[owner_q];
    assign s_lock_o = o_lock;
    assign s_adr_o  = own ? m_adr_i[owner_q*WB_ADDR_W +: WB_ADDR_W] : '0;
    assign s_dat_o  = own ? m_dat_i[owner_q*WB_DATA_W +: WB_DATA_W] : '0;
    assign s_sel_o  = own ? m_sel_i[owner_q*SW +: SW] : '0;
    assign s_cti_o  = own ? m_cti_i[owner_q*3 +: 3] : '0;
    assign s_bte_o  = own ? m_bte_i[owner_q*2 +: 2] : '0;

    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = gnt_q & {NUM_M{s_ack_i & s_cyc_o}};
    assign m_err_o   = gnt_q & {NUM_M{(s_err_i & s_cyc_o) | fire}};
    assign m_rty_o   = gnt_q & {NUM_M{s_rty_i & s_cyc_o}};
    assign gnt_o     = gnt_q;
    assign timeout_o = fire;

    // watchdog runs only while a strobe is outstanding and unanswered
    always_comb wd_d = (s_stb_o & ~term) ? wd_q + 10'd1 : 10'd0;

    // grant FSM: arbitrate when idle, hold until released or timed out
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= ST_ARB;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wd_q     <= '0;
        end else begin
            wd_q <= wd_d;
            if (state_q == ST_ARB) begin
                if (|m_cyc_i) begin
                    state_q <= ST_OWN;
                    gnt_q   <= pick_gnt;
                    owner_q <= pick_idx;
                end
            end else if (rel) begin
                state_q  <= ST_ARB;
                gnt_q    <= '0;
                rr_ptr_q <= (owner_q == IW'(NUM_M - 1)) ? '0 : owner_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb_wishbone_arbiter: directed scoreboard bench for the round-robin Wishbone arbiter
module tb_wishbone_arbiter;
    import wishbone_pkg::*;
    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NM-1:0] cyc = '0, stb = '0, we = '0, lock = '0;
    logic [NM-1:0][AW-1:0]   adr = '0;
    logic [NM-1:0][DW-1:0]   dat = '0;
    logic [NM-1:0][DW/8-1:0] sel = '0;
    logic [NM-1:0][2:0]      cti = '0;
    logic [NM-1:0][1:0]      bte = '0;
    logic [DW-1:0] s_dat_i = '0;
    logic s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

    logic [NM-1:0]   m_ack_o, m_err_o, m_rty_o, gnt_o;
    logic [DW-1:0]   m_dat_o, s_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o, s_lock_o, timeout_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW/8-1:0] s_sel_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    wishbone_arbiter #(.NUM_M(NM), .WB_ADDR_W(AW), .WB_DATA_W(DW), .TIMEOUT(8)) dut (
        .CLK_I(clk), .RST_I(rst),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_lock_i(lock),
        .m_adr_i(adr), .m_dat_i(dat), .m_sel_i(sel), .m_cti_i(cti), .m_bte_i(bte),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_lock_o(s_lock_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_bte_o(s_bte_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
        .s_rty_i(s_rty), .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NM-1:0] drop;
        logic [NM-1:0] prev;
        int gap;
        int e;
        bit first;
        drop = '0;
        prev = '0;
        gap = 0;
        first = 1'b1;
        cyc[0] = 1'b1;
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_scyc", 32'(s_cyc_o), 0);
        chk("rst_sstb", 32'(s_stb_o), 0);
        chk("rst_sadr", s_adr_o, 0);
        chk("rst_term", 32'({m_ack_o, m_err_o, m_rty_o, timeout_o}), 0);
        cyc[0] = 1'b0;
        rst = 1'b0;
        // single requester: master 2
        tick();
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        adr[2] = 32'h100; dat[2] = 32'hCAFE0002; sel[2] = 4'hF;
        #1;
        chk("t1_gnt_c0", 32'(gnt_o), 0);
        tick();
        chk("t1_gnt_c1", 32'(gnt_o), 32'h4);
        chk("t1_sadr", s_adr_o, 32'h100);
        chk("t1_sdat", s_dat_o, 32'hCAFE0002);
        chk("t1_swe_sel", 32'({s_we_o, s_sel_o}), 32'h1F);
        tick();
        tick();
        s_ack = 1'b1; s_dat_i = 32'h12345678;
        #1;
        chk("t1_ack", 32'(m_ack_o), 32'h4);
        chk("t1_rdat", m_dat_o, 32'h12345678);
        tick();
        s_ack = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        #1;
        chk("t1_gnt_c4", 32'(gnt_o), 32'h4);
        chk("t1_scyc_c4", 32'(s_cyc_o), 0);
        tick();
        chk("t1_gnt_c5", 32'(gnt_o), 0);
        // contention among 0,1,3 from a fresh pointer
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_q = {0, 1, 3, 0};
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            tick();
            for (int i = 0; i < NM; i++) begin
                if (i != 2) begin
                    cyc[i] = !drop[i];
                    stb[i] = !drop[i];
                end
            end
            drop = '0;
            s_ack = 1'b0;
            #1;
            s_ack = s_cyc_o & s_stb_o;
            #1;
            if (gnt_o != 0 && prev == 0) begin
                e = exp_q.pop_front();
                chk("rr_order", 32'(gnt_o), 32'(1) << e);
                if (!first) chk("rr_gap", gap, 1);
                first = 1'b0;
                gap = 0;
            end
            if (gnt_o == 0) gap++;
            if (s_ack) chk("rr_ack_route", 32'(m_ack_o), 32'(gnt_o));
            for (int i = 0; i < NM; i++) if (m_ack_o[i]) drop[i] = 1'b1;
            prev = gnt_o;
        end
        chk("rr_done", exp_q.size(), 0);
        tick();
        cyc = '0; stb = '0; s_ack = 1'b0;
        tick();
        tick();
        chk("rr_idle", 32'(gnt_o), 0);
        // locked burst by master 1 while master 0 waits
        cyc[1] = 1'b1; stb[1] = 1'b1; lock[1] = 1'b1; cti[1] = CTI_INCR; adr[1] = 32'h200;
        tick();
        chk("lk_gnt", 32'(gnt_o), 32'h2);
        chk("lk_slock", 32'(s_lock_o), 1);
        for (int b = 0; b < 4; b++) begin
            cti[1] = (b == 3) ? CTI_EOB : CTI_INCR;
            s_ack = 1'b1;
            #1;
            chk("lk_cti", 32'(s_cti_o), (b == 3) ? 32'h7 : 32'h2);
            chk("lk_ack", 32'(m_ack_o), 32'h2);
            tick();
        end
        s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; cti[1] = CTI_CLASSIC;
        cyc[0] = 1'b1;
        #1;
        chk("lk_hold0", 32'(gnt_o), 32'h2);
        tick();
        chk("lk_hold1", 32'(gnt_o), 32'h2);
        tick();
        chk("lk_hold2", 32'(gnt_o), 32'h2);
        cyc[1] = 1'b1; stb[1] = 1'b1; s_ack = 1'b1;
        #1;
        chk("lk_resume_ack", 32'(m_ack_o), 32'h2);
        tick();
        cyc[1] = 1'b0; stb[1] = 1'b0; lock[1] = 1'b0; s_ack = 1'b0;
        #1;
        chk("lk_unlock", 32'(gnt_o), 32'h2);
        tick();
        chk("lk_gap", 32'(gnt_o), 0);
        tick();
        chk("lk_m0_gnt", 32'(gnt_o), 32'h1);
        // watchdog: master 0 strobes a silent slave
        stb[0] = 1'b1;
        #1;
        repeat (7) tick();
        chk("wd_pre_to", 32'(timeout_o), 0);
        chk("wd_pre_stb", 32'(s_stb_o), 1);
        tick();
        chk("wd_to", 32'(timeout_o), 1);
        chk("wd_err", 32'(m_err_o), 32'h1);
        chk("wd_scyc", 32'({s_cyc_o, s_stb_o}), 0);
        tick();
        chk("wd_gnt_after", 32'(gnt_o), 0);
        chk("wd_to_after", 32'(timeout_o), 0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        // termination collision: master 3, ACK exactly at terminal count
        tick();
        cyc[3] = 1'b1; stb[3] = 1'b1;
        tick();
        chk("col_gnt", 32'(gnt_o), 32'h8);
        repeat (8) tick();
        s_ack = 1'b1;
        #1;
        chk("col_ack", 32'(m_ack_o), 32'h8);
        chk("col_err", 32'(m_err_o), 0);
        chk("col_to", 32'(timeout_o), 0);
        tick();
        s_ack = 1'b0;
        #1;
        chk("col_to_next", 32'(timeout_o), 0);
        chk("col_gnt_next", 32'(gnt_o), 32'h8);
        cyc[3] = 1'b0; stb[3] = 1'b0;
        tick();
        tick();
        // move the pointer off zero, then reset during a burst
        cyc[1] = 1'b1; stb[1] = 1'b1;
        tick();
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        tick();
        cyc[2] = 1'b1; stb[2] = 1'b1; cti[2] = CTI_INCR;
        tick();
        chk("rb_gnt", 32'(gnt_o), 32'h4);
        s_ack = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("rb_gnt_rst", 32'(gnt_o), 0);
        chk("rb_scyc_rst", 32'(s_cyc_o), 0);
        chk("rb_ack_rst", 32'(m_ack_o), 0);
        s_ack = 1'b0;
        cyc[0] = 1'b1; cyc[3] = 1'b1;
        tick();
        chk("rb_gnt_held", 32'(gnt_o), 0);
        rst = 1'b0;
        tick();
        chk("rb_prio0", 32'(gnt_o), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wishbone_arbiter.md
# wishbone_arbiter

Round-robin arbiter that shares one Wishbone B4 slave port among `NUM_M` request-generating masters such as `wishbone_master` instances in the example system. It owns the grant, muxes the granted master's address, data and cycle-type signals onto the slave port, and routes termination signals back to that master only. A watchdog per access ends stalled transfers with ERR so that one slave cannot hang the bus.

## Interface
- `NUM_M`, 4: number of masters (2..8)
- `WB_ADDR_W`, 32: address width
- `WB_DATA_W`, 32: data width; SEL width is `WB_DATA_W/8`
- `TIMEOUT`, 255: watchdog limit in cycles (1..1023)

Clock/reset: one clock; reset is asynchronous and active-high.
- `CLK_I` in 1: clock
- `RST_I` in 1: asynchronous active-high reset
- `m_cyc_i`, `m_stb_i`, `m_we_i`, `m_lock_i` in NUM_M each: per-master Wishbone controls, bit i = master i
- `m_adr_i` in NUM_M*WB_ADDR_W: packed addresses, master i at slice i
- `m_dat_i` in NUM_M*WB_DATA_W: packed write data
- `m_sel_i` in NUM_M*WB_DATA_W/8: packed byte selects
- `m_cti_i` in NUM_M*3, `m_bte_i` in NUM_M*2: packed burst tags
- `m_ack_o`, `m_err_o`, `m_rty_o` out NUM_M each: per-master terminations
- `m_dat_o` out WB_DATA_W: read data, broadcast to all masters
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_lock_o` out 1: slave-side controls
- `s_adr_o` out WB_ADDR_W, `s_dat_o` out WB_DATA_W, `s_sel_o` out WB_DATA_W/8, `s_cti_o` out 3, `s_bte_o` out 2: muxed slave-side signals
- `s_dat_i` in WB_DATA_W, `s_ack_i`, `s_err_i`, `s_rty_i` in 1: slave responses
- `gnt_o` out NUM_M: one-hot grant, all zero when idle
- `timeout_o` out 1: one-cycle pulse when the watchdog fires

## Operation
- FSM states:
  - ARB: no owner, `gnt_o` = 0, all `s_*` outputs 0.
  - OWN: one owner.
- ARB to OWN: any `m_cyc_i` bit set. The winner is the first requester at or after `rr_ptr`, searching upward with wrap. The winner is registered into `gnt_o`.
- OWN to ARB when either condition holds:
  - The owner has `m_cyc_i`=0 and `m_lock_i`=0. While the owner holds `m_lock_i`=1, it keeps the grant even when CYC is low between cycles.
  - The watchdog fires.
- On release, `rr_ptr` is set to owner+1 mod NUM_M.
- After every release there is a mandatory single ARB cycle (bus idle gap) before the next grant.
- In OWN, the `s_*` outputs are a combinational mux of the owner's inputs. `s_cyc_o` = owner CYC. `s_stb_o` = owner CYC & STB.
- `s_ack_i`, `s_err_i`, `s_rty_i` are routed only to the owner bit, gated by `s_cyc_o`. Non-owners always see 0.
- `m_dat_o` = `s_dat_i` unconditionally.
- CTI/BTE pass through unchanged. Burst atomicity comes from holding the grant while CYC stays high.
- Watchdog counter, 10 bits:
  - Cleared in ARB, when `s_stb_o`=0, or on any termination.
  - Otherwise increments.
  - When it equals `TIMEOUT`, the arbiter drives `m_err_o[owner]`=1 and `timeout_o`=1 for that cycle, forces `s_cyc_o`/`s_stb_o` to 0 in the same cycle, and goes to ARB, even if the owner holds LOCK.
- Simultaneous slave termination and watchdog terminal count: the slave termination wins, no ERR is injected, and the counter clears.
- A master dropping CYC mid-burst is legal. It releases per the rule above.

## Timing
- Reset values:
  - state = ARB, `gnt_o` = 0, `rr_ptr` = 0, counter = 0.
  - All `m_ack_o`/`m_err_o`/`m_rty_o`, all `s_*` outputs, and `timeout_o` are 0.
- Grant latency: CYC rises at cycle N in ARB, `gnt_o` and `s_cyc_o` rise at N+1.
- Release: owner CYC low at cycle N, `gnt_o` = 0 at N+1, next grant at N+2 at the earliest.
- Termination path from `s_*_i` to `m_*_o` is combinational, zero latency.
- Reset asserted mid-transfer: outputs clear immediately (asynchronous). No termination is generated for the aborted access.

## Structure
- Shared package `wishbone_pkg`: CTI constants (000, 001, 010, 111), BTE constants (00..11), arbiter state enum.
- Sub-module `wb_rr_picker`: combinational, inputs `req[NUM_M]` and `ptr`, outputs one-hot `gnt` and encoded index. It is reusable for other shared resources.
- Top level: FSM, grant/pointer registers, watchdog, output muxes.

## Test plan
- Single requester: master 2 asserts CYC/STB with adr 0x100 at cycle 0 → `gnt_o`=0100 at cycle 1; `s_adr_o`=0x100; slave ACK at cycle 3 reaches only `m_ack_o[2]`.
- Contention: masters 0, 1, 3 request continuously with single-beat cycles, each dropping CYC after ACK → grant order 0, 1, 3, 0, with exactly one idle cycle between grants.
- Locked burst: master 1 holds LOCK and runs 4-beat CTI=010 then CTI=111, drops CYC for 2 cycles, then resumes while master 0 requests → master 0 is not granted until master 1 drops LOCK.
- Watchdog: `TIMEOUT`=8, owner STB high with the slave silent → `m_err_o[owner]` and `timeout_o` pulse 8 cycles after the STB edge; `gnt_o`=0 on the next cycle.
- Termination collision: slave ACK arrives exactly on the terminal count → ACK delivered, no ERR, no `timeout_o`.
- Reset mid-burst: `RST_I` is asserted during beat 2 → `gnt_o` and `s_cyc_o` are 0 the same cycle; after release, master 0 has first priority.
